// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared types and constants for the glitch trigger and glitch stages
package glitch_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        DELAY     = 3'd2,
        FIRE      = 3'd3,
        WAIT_BUSY = 3'd4
    } trig_state_t;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    localparam int HOLDOFF_CYCLES = 2000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, stability debounce and press pulse
module btn_debounce
    import glitch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_press
);

    localparam int CW = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn_in;
            sync2    <= sync1;
            stable_d <= stable;
            // Any sample that agrees with the stable value restarts the count
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign btn_press = stable & ~stable_d;

endmodule

// File: rtl/glitch_trigger_ctrl.sv
// rtl/glitch_trigger_ctrl.sv - trigger conditioning, offset delay and fire sequencing for the glitch stage
module glitch_trigger_ctrl
    import glitch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DELAY_W         = 16,
    parameter int MISS_TIMEOUT    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_in,
    input  logic               target_trig,
    input  logic               trig_sel,
    input  logic [DELAY_W-1:0] delay_cfg,
    input  logic               glitch_busy,
    output logic               fire,
    output logic               armed,
    output logic               busy,
    output logic               miss
);

    localparam int MW = ($clog2(MISS_TIMEOUT) > 0) ? $clog2(MISS_TIMEOUT) : 1;

    logic               btn_press;
    logic               tgt_s1;
    logic               tgt_s2;
    logic               tgt_d;
    logic               tgt_edge;
    trig_state_t        state;
    trig_state_t        state_nxt;
    logic [DELAY_W-1:0] cnt;
    logic [DELAY_W-1:0] cnt_nxt;
    logic               seen;
    logic               seen_nxt;
    logic [MW-1:0]      wcnt;
    logic [MW-1:0]      wcnt_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .btn_press (btn_press)
    );

    assign tgt_edge = tgt_s2 & ~tgt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_s1 <= 1'b0;
            tgt_s2 <= 1'b0;
            tgt_d  <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            seen   <= 1'b0;
            wcnt   <= '0;
        end else begin
            tgt_s1 <= target_trig;
            tgt_s2 <= tgt_s1;
            tgt_d  <= tgt_s2;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            seen   <= seen_nxt;
            wcnt   <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        seen_nxt  = seen;
        wcnt_nxt  = wcnt;
        miss      = 1'b0;
        case (state)
            IDLE: begin
                if (btn_press && !glitch_busy) begin
                    if (trig_sel) begin
                        state_nxt = ARMED;
                    end else begin
                        state_nxt = DELAY;
                        cnt_nxt   = delay_cfg;
                    end
                end
            end
            ARMED: begin
                // A second press aborts even if the target edge lands in the same cycle
                if (btn_press) begin
                    state_nxt = IDLE;
                end else if (tgt_edge) begin
                    state_nxt = DELAY;
                    cnt_nxt   = delay_cfg;
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    state_nxt = FIRE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            FIRE: begin
                state_nxt = WAIT_BUSY;
                seen_nxt  = 1'b0;
                wcnt_nxt  = '0;
            end
            WAIT_BUSY: begin
                if (seen && !glitch_busy) begin
                    state_nxt = IDLE;
                end else if (!seen && !glitch_busy && wcnt == MW'(MISS_TIMEOUT - 1)) begin
                    miss      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    seen_nxt = seen | glitch_busy;
                    if (wcnt != MW'(MISS_TIMEOUT - 1)) begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fire  = (state == FIRE);
    assign armed = (state == ARMED);
    assign busy  = (state != IDLE);

endmodule
